// File: rtl/uart_cmd_ctrl.sv
// UART command controller: collects terminated commands from the byte receiver,
// hands them to the executor over valid/ready and returns a one-byte reply.
module uart_cmd_ctrl #(
    parameter int          CMD_MAX = 8,
    parameter logic [7:0]  TERM    = 8'h0D,
    parameter logic [7:0]  ACK     = 8'h4B,
    parameter logic [7:0]  NAK     = 8'h45,
    parameter logic [7:0]  ERR     = 8'h21,
    parameter int          TIMEOUT = 1000000,
    parameter int          LEN_W   = $clog2(CMD_MAX + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic [7:0]             tx_data,
    output logic                   tx_start,
    input  logic                   tx_busy,
    output logic [8*CMD_MAX-1:0]   cmd_data,
    output logic [LEN_W-1:0]       cmd_len,
    output logic                   cmd_valid,
    input  logic                   cmd_ready,
    input  logic                   cmd_done,
    input  logic                   cmd_ok,
    output logic [1:0]             state_out
);

    typedef enum logic [1:0] {
        S_START = 2'd0,
        S_READ  = 2'd1,
        S_RUN   = 2'd2,
        S_ERROR = 2'd3
    } state_t;

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(CMD_MAX);
    localparam logic [31:0]      TO_LIM  = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

    state_t      state, state_nxt;
    logic [31:0] timer;
    logic [31:0] timer_inc;
    logic        expire;
    logic [7:0]  reply;
    logic        reply_pend;
    logic        discard;
    logic        term_seen;
    logic        err_sent;
    logic        accepted;
    logic        done_taken;

    logic        rx_term;
    logic        first_byte;
    logic        store_byte;
    logic        term_in_read;
    logic        overflow;
    logic        timeout_hit;
    logic        hs;
    logic        done_take;
    logic        tx_fire;

    assign state_out = state;
    assign timer_inc = timer + 32'd1;
    assign expire    = (TIMEOUT != 0) && (timer_inc >= TO_LIM);
    assign rx_term   = rx_valid && (rx_data == TERM);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_START;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_START: begin
                if (rx_valid && !rx_term) state_nxt = S_READ;
            end
            S_READ: begin
                if (rx_valid) begin
                    if (rx_term)                  state_nxt = S_RUN;
                    else if (cmd_len == LEN_MAX)  state_nxt = S_ERROR;
                end else if (expire) begin
                    state_nxt = S_ERROR;
                end
            end
            S_RUN: begin
                if (tx_start) state_nxt = S_START;
            end
            S_ERROR: begin
                // Overflow recovery needs both the ERR byte sent and a terminator seen.
                if ((tx_start || err_sent) && (!discard || term_seen || rx_term))
                    state_nxt = S_START;
            end
            default: state_nxt = S_START;
        endcase
    end

    always_comb begin
        first_byte   = 1'b0;
        store_byte   = 1'b0;
        term_in_read = 1'b0;
        overflow     = 1'b0;
        timeout_hit  = 1'b0;
        hs           = cmd_valid && cmd_ready;
        done_take    = 1'b0;
        tx_fire      = reply_pend && !tx_busy;
        case (state)
            S_START: first_byte = rx_valid && !rx_term;
            S_READ: begin
                term_in_read = rx_term;
                store_byte   = rx_valid && !rx_term && (cmd_len != LEN_MAX);
                overflow     = rx_valid && !rx_term && (cmd_len == LEN_MAX);
                timeout_hit  = !rx_valid && expire;
            end
            S_RUN: begin
                // Completion only counts once the executor has taken the command.
                done_take = cmd_done && (accepted || hs) && !done_taken;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_data   <= '0;
            cmd_len    <= '0;
            cmd_valid  <= 1'b0;
            tx_start   <= 1'b0;
            tx_data    <= 8'h00;
            timer      <= 32'd0;
            reply      <= 8'h00;
            reply_pend <= 1'b0;
            discard    <= 1'b0;
            term_seen  <= 1'b0;
            err_sent   <= 1'b0;
            accepted   <= 1'b0;
            done_taken <= 1'b0;
        end else begin
            if (first_byte) begin
                cmd_data      <= '0;
                cmd_data[7:0] <= rx_data;
                cmd_len       <= LEN_W'(1);
            end else if (store_byte) begin
                for (int i = 0; i < CMD_MAX; i++) begin
                    if (cmd_len == LEN_W'(i)) cmd_data[8*i +: 8] <= rx_data;
                end
                cmd_len <= cmd_len + LEN_W'(1);
            end

            if (first_byte || store_byte)       timer <= 32'd0;
            else if (state == S_READ && !rx_valid) timer <= timer_inc;

            if (term_in_read) cmd_valid <= 1'b1;
            else if (hs)      cmd_valid <= 1'b0;

            accepted   <= (state == S_RUN) && (accepted || hs);
            done_taken <= (state == S_RUN) && (done_taken || done_take);

            if (overflow)         discard <= 1'b1;
            else if (timeout_hit) discard <= 1'b0;
            term_seen <= (state == S_ERROR) && (term_seen || rx_term);
            err_sent  <= (state == S_ERROR) && (err_sent || tx_start);

            if (done_take) begin
                reply_pend <= 1'b1;
                reply      <= cmd_ok ? ACK : NAK;
            end else if (overflow || timeout_hit) begin
                reply_pend <= 1'b1;
                reply      <= ERR;
            end else if (tx_fire) begin
                reply_pend <= 1'b0;
            end

            tx_start <= tx_fire;
            if (tx_fire) tx_data <= reply;
        end
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl with CMD_MAX=4 and TIMEOUT=16.
module tb_uart_cmd_ctrl;

    localparam int CMD_MAX = 4;
    localparam int TIMEOUT = 16;
    localparam int LEN_W   = $clog2(CMD_MAX + 1);

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [7:0]           rx_data;
    logic                 rx_valid;
    logic [7:0]           tx_data;
    logic                 tx_start;
    logic                 tx_busy;
    logic [8*CMD_MAX-1:0] cmd_data;
    logic [LEN_W-1:0]     cmd_len;
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_done;
    logic                 cmd_ok;
    logic [1:0]           state_out;

    int n_chk = 0;
    int n_err = 0;
    int n_tx  = 0;
    int n_vld = 0;
    logic [7:0] tx_last = 8'h00;
    int tx0;
    int vld0;

    uart_cmd_ctrl #(
        .CMD_MAX (CMD_MAX),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .cmd_data  (cmd_data),
        .cmd_len   (cmd_len),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_done  (cmd_done),
        .cmd_ok    (cmd_ok),
        .state_out (state_out)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_start) begin
            n_tx++;
            tx_last = tx_data;
        end
        if (cmd_valid) n_vld++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_state"}, 32'(state_out), 32'd0);
        chk({tag, "_data"},  32'(cmd_data),  32'd0);
        chk({tag, "_len"},   32'(cmd_len),   32'd0);
        chk({tag, "_valid"}, 32'(cmd_valid), 32'd0);
        chk({tag, "_txs"},   32'(tx_start),  32'd0);
        chk({tag, "_txd"},   32'(tx_data),   32'd0);
    endtask

    // Completes an accepted command with ACK and returns to START.
    task automatic finish_ok();
        cmd_done = 1'b1;
        cmd_ok   = 1'b1;
        tick();
        cmd_done = 1'b0;
        tick();
        tick();
        tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        tx_busy   = 1'b0;
        cmd_ready = 1'b0;
        cmd_done  = 1'b0;
        cmd_ok    = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Basic command with ACK
        cmd_ready = 1'b1;
        tx0 = n_tx;
        send(8'h41);
        chk("basic_read", 32'(state_out), 32'd1);
        send(8'h42);
        send(8'h0D);
        chk("basic_valid", 32'(cmd_valid), 32'd1);
        chk("basic_run",   32'(state_out), 32'd2);
        chk("basic_data",  32'(cmd_data),  32'h0000_4241);
        chk("basic_len",   32'(cmd_len),   32'd2);
        tick();
        chk("basic_vdrop", 32'(cmd_valid), 32'd0);
        cmd_done = 1'b1;
        cmd_ok   = 1'b1;
        tick();
        cmd_done = 1'b0;
        chk("basic_notx_yet", 32'(tx_start), 32'd0);
        tick();
        chk("basic_txs", 32'(tx_start), 32'd1);
        chk("basic_txd", 32'(tx_data),  32'h4B);
        tick();
        chk("basic_start", 32'(state_out), 32'd0);
        chk("basic_txs_off", 32'(tx_start), 32'd0);
        tick();
        chk("basic_ntx", 32'(n_tx - tx0), 32'd1);

        // NAK with backpressure and a busy transmitter
        cmd_ready = 1'b0;
        tx0  = n_tx;
        send(8'h50);
        send(8'h51);
        vld0 = n_vld;
        send(8'h0D);
        for (int i = 0; i < 5; i++) begin
            chk("nak_hold", 32'(cmd_valid), 32'd1);
            tick();
        end
        chk("nak_hold6", 32'(cmd_valid), 32'd1);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        chk("nak_vdrop", 32'(cmd_valid), 32'd0);
        chk("nak_vcnt",  32'(n_vld - vld0), 32'd6);
        tx_busy  = 1'b1;
        cmd_done = 1'b1;
        cmd_ok   = 1'b0;
        tick();
        cmd_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("nak_busy_notx", 32'(tx_start), 32'd0);
            chk("nak_stable",    32'(cmd_data), 32'h0000_5150);
            if (i < 2) tick();
        end
        tx_busy = 1'b0;
        tick();
        chk("nak_txs", 32'(tx_start), 32'd1);
        chk("nak_txd", 32'(tx_data),  32'h45);
        chk("nak_len", 32'(cmd_len),  32'd2);
        tick();
        chk("nak_start", 32'(state_out), 32'd0);
        chk("nak_ntx",   32'(n_tx - tx0), 32'd1);

        // Overflow with discard until terminator
        cmd_ready = 1'b1;
        tx0  = n_tx;
        vld0 = n_vld;
        send(8'h31);
        send(8'h32);
        send(8'h33);
        send(8'h34);
        chk("ovf_full", 32'(state_out), 32'd1);
        send(8'h35);
        chk("ovf_err",  32'(state_out), 32'd3);
        chk("ovf_notx", 32'(tx_start),  32'd0);
        tick();
        chk("ovf_txs", 32'(tx_start), 32'd1);
        chk("ovf_txd", 32'(tx_data),  32'h21);
        send(8'h33);
        chk("ovf_discard", 32'(state_out), 32'd3);
        send(8'h0D);
        chk("ovf_start", 32'(state_out), 32'd0);
        tick();
        chk("ovf_ntx",  32'(n_tx - tx0),   32'd1);
        chk("ovf_nvld", 32'(n_vld - vld0), 32'd0);

        // Timeout after a single byte
        tx0 = n_tx;
        send(8'h41);
        for (int i = 0; i < 14; i++) tick();
        chk("to_before", 32'(state_out), 32'd1);
        tick();
        chk("to_err", 32'(state_out), 32'd3);
        tick();
        chk("to_txs", 32'(tx_start), 32'd1);
        chk("to_txd", 32'(tx_data),  32'h21);
        tick();
        chk("to_start", 32'(state_out), 32'd0);
        chk("to_ntx",   32'(n_tx - tx0), 32'd1);

        // Byte in the expiry cycle keeps the command alive
        send(8'h41);
        for (int i = 0; i < 14; i++) tick();
        send(8'h42);
        chk("to_race_read", 32'(state_out), 32'd1);
        chk("to_race_len",  32'(cmd_len),   32'd2);
        send(8'h0D);
        chk("to_race_data", 32'(cmd_data), 32'h0000_4241);
        tick();
        finish_ok();
        chk("to_race_done", 32'(state_out), 32'd0);

        // Empty command and bytes dropped during execution
        vld0 = n_vld;
        send(8'h0D);
        chk("empty_state", 32'(state_out), 32'd0);
        tick();
        chk("empty_novld", 32'(n_vld - vld0), 32'd0);
        send(8'h61);
        send(8'h0D);
        tick();
        send(8'h77);
        send(8'h78);
        chk("drop_run", 32'(state_out), 32'd2);
        chk("drop_data_held", 32'(cmd_data), 32'h0000_0061);
        finish_ok();
        chk("drop_start", 32'(state_out), 32'd0);
        send(8'h62);
        send(8'h0D);
        chk("drop_len",  32'(cmd_len),  32'd1);
        chk("drop_data", 32'(cmd_data), 32'h0000_0062);
        tick();
        finish_ok();

        // Reset during CMD_READ
        tx0 = n_tx;
        send(8'h41);
        chk("rst_read_pre", 32'(state_out), 32'd1);
        rst_n = 1'b0;
        tick();
        check_reset_outputs("rst_read");
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("rst_read_ntx", 32'(n_tx - tx0), 32'd0);

        // Reset during CMD_RUN with a reply pending
        send(8'h41);
        send(8'h0D);
        chk("rst_run_pre", 32'(state_out), 32'd2);
        tick();
        tx_busy  = 1'b1;
        cmd_done = 1'b1;
        cmd_ok   = 1'b1;
        tick();
        cmd_done = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        check_reset_outputs("rst_run");
        rst_n   = 1'b1;
        tx_busy = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("rst_run_ntx",   32'(n_tx - tx0), 32'd0);
        chk("rst_run_state", 32'(state_out),  32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
